// File: rtl/xbox_port_arbiter.sv
// Round-robin arbiter sharing the XBOX row port between TPUM requesters, with read-return
// routing and a flush/drain handshake. Optional burst lock: define XBOX_ARB_BURST_LOCK_EN.
module xbox_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int RD_LAT  = 2,
  parameter int AW      = 14,
  parameter int DW      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
`ifdef XBOX_ARB_BURST_LOCK_EN
  input  logic [NUM_REQ-1:0]    req_lock,
`endif
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    rvalid,
  output logic [DW-1:0]         rdata,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  busy,
  output logic                  pum_rd_from_XBOX,
  output logic                  pum_wr_To_XBOX,
  output logic [AW-1:0]         pum_XBOX_addr,
  output logic [DW-1:0]         pum_XBOX_wdata,
  input  logic [DW-1:0]         pum_XBOX_rdata
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(RD_LAT + 2);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t                          r_state;
  logic                            r_done_sent;
  logic                            r_flush_done;
  logic [PW-1:0]                   r_ptr;
  logic                            r_cmd_vld;
  logic                            r_cmd_we;
  logic [NUM_REQ-1:0]              r_cmd_id;
  logic [AW-1:0]                   r_addr;
  logic [DW-1:0]                   r_wdata;
  logic [RD_LAT-1:0]               r_tag_vld;
  logic [RD_LAT-1:0][NUM_REQ-1:0]  r_tag_id;
  logic [CW-1:0]                   r_inflight;

  logic               w_arb_en;
  logic               w_any_gnt;
  logic [PW-1:0]      w_win;
  logic [PW-1:0]      w_ptr_eff;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_inc;
  logic               w_ret;
  logic [CW-1:0]      w_inflight_nxt;
  logic               w_drained_nxt;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef XBOX_ARB_BURST_LOCK_EN
  logic          r_lock_vld;
  logic [PW-1:0] r_lock_id;
  logic          w_lock_hold;
  assign w_lock_hold = r_lock_vld && req[r_lock_id] && req_lock[r_lock_id];
  // A released lock resumes round-robin just past the former lock holder.
  assign w_ptr_eff   = r_lock_vld ? nxt(r_lock_id) : r_ptr;
`else
  assign w_ptr_eff   = r_ptr;
`endif

  assign w_arb_en = !rst && !flush && (r_state != DRAIN);

  always_comb begin
    int idx;
    idx       = 0;
    w_gnt     = '0;
    w_win     = '0;
    w_any_gnt = 1'b0;
    if (w_arb_en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(w_ptr_eff) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!w_any_gnt && req[idx]) begin
          w_any_gnt = 1'b1;
          w_win     = PW'(idx);
        end
      end
`ifdef XBOX_ARB_BURST_LOCK_EN
      if (w_lock_hold) begin
        w_any_gnt = 1'b1;
        w_win     = r_lock_id;
      end
`endif
    end
    if (w_any_gnt) w_gnt[w_win] = 1'b1;
  end

  assign gnt              = w_gnt;
  assign pum_rd_from_XBOX = r_cmd_vld & ~r_cmd_we;
  assign pum_wr_To_XBOX   = r_cmd_vld & r_cmd_we;
  assign pum_XBOX_addr    = r_addr;
  assign pum_XBOX_wdata   = r_wdata;
  assign w_inc            = pum_rd_from_XBOX;
  assign w_ret            = r_tag_vld[RD_LAT-1];
  assign rvalid           = w_ret ? r_tag_id[RD_LAT-1] : '0;
  assign rdata            = w_ret ? pum_XBOX_rdata : '0;
  assign busy             = r_cmd_vld | (r_inflight != '0);
  assign flush_done       = r_flush_done;
  assign w_inflight_nxt   = r_inflight + CW'(w_inc) - CW'(w_ret);
  // Nothing staged and nothing outstanding once this edge has been taken.
  assign w_drained_nxt    = !w_any_gnt && (w_inflight_nxt == '0);

  // Command stage, return tags and in-flight count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_vld  <= 1'b0;
      r_cmd_we   <= 1'b0;
      r_cmd_id   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_tag_vld  <= '0;
      r_tag_id   <= '0;
      r_inflight <= '0;
    end else begin
      r_cmd_vld <= w_any_gnt;
      if (w_any_gnt) begin
        r_cmd_we <= req_we[w_win];
        r_cmd_id <= w_gnt;
        r_addr   <= req_addr[int'(w_win)*AW +: AW];
        r_wdata  <= req_wdata[int'(w_win)*DW +: DW];
      end
      r_tag_vld[0] <= w_inc;
      r_tag_id[0]  <= r_cmd_id;
      for (int k = 1; k < RD_LAT; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_id[k]  <= r_tag_id[k-1];
      end
      r_inflight <= w_inflight_nxt;
    end
  end

  // Round-robin pointer (and lock ownership when enabled).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
`ifdef XBOX_ARB_BURST_LOCK_EN
      r_lock_vld <= 1'b0;
      r_lock_id  <= '0;
`endif
    end else begin
`ifdef XBOX_ARB_BURST_LOCK_EN
      if (w_any_gnt) begin
        r_lock_vld <= req_lock[w_win];
        r_lock_id  <= w_win;
        if (!req_lock[w_win]) r_ptr <= nxt(w_win);
      end else if (r_lock_vld && !w_lock_hold) begin
        r_lock_vld <= 1'b0;
        r_ptr      <= w_ptr_eff;
      end
`else
      if (w_any_gnt) r_ptr <= nxt(w_win);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_done_sent  <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      case (r_state)
        IDLE, ACTIVE: begin
          if (flush) begin
            r_state     <= DRAIN;
            r_done_sent <= 1'b0;
            if (w_drained_nxt) begin
              r_flush_done <= 1'b1;
              r_done_sent  <= 1'b1;
            end
          end else if (w_any_gnt) begin
            r_state <= ACTIVE;
          end else if (r_state == ACTIVE && !r_cmd_vld && r_inflight == '0) begin
            r_state <= IDLE;
          end
        end
        DRAIN: begin
          // One pulse per flush assertion; a held flush parks here with grants blocked.
          if (!r_done_sent && w_drained_nxt) begin
            r_flush_done <= 1'b1;
            r_done_sent  <= 1'b1;
            if (!flush) r_state <= IDLE;
          end else if (r_done_sent && !flush) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xbox_port_arbiter.sv
// Self-checking bench for xbox_port_arbiter: directed scenarios plus a randomized run
// scored against a cycle-level model of the port's arbitration, return and drain rules.
module tb_xbox_port_arbiter;
  localparam int NUM_REQ = 3;
  localparam int RD_LAT  = 2;
  localparam int AW      = 14;
  localparam int DW      = 1024;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req, req_we;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
`ifdef XBOX_ARB_BURST_LOCK_EN
  logic [NUM_REQ-1:0]    req_lock;
`endif
  logic [NUM_REQ-1:0]    gnt, rvalid;
  logic [DW-1:0]         rdata;
  logic                  flush, flush_done, busy;
  logic                  pum_rd, pum_wr;
  logic [AW-1:0]         pum_addr;
  logic [DW-1:0]         pum_wdata, pum_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct { int due; int id; logic [AW-1:0] addr; } ret_t;

  xbox_port_arbiter #(.NUM_REQ(NUM_REQ), .RD_LAT(RD_LAT), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata),
`ifdef XBOX_ARB_BURST_LOCK_EN
    .req_lock(req_lock),
`endif
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .flush(flush),
    .flush_done(flush_done), .busy(busy), .pum_rd_from_XBOX(pum_rd),
    .pum_wr_To_XBOX(pum_wr), .pum_XBOX_addr(pum_addr), .pum_XBOX_wdata(pum_wdata),
    .pum_XBOX_rdata(pum_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = {8'hA5, 2'b00, a, 8'(i)};
    return v;
  endfunction

  function automatic logic [DW-1:0] rnd_dw();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0; flush = 1'b0;
    pum_rdata = rnd_dw();
`ifdef XBOX_ARB_BURST_LOCK_EN
    req_lock = '0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req[i] = 1'b1; req_we[i] = we;
    req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    logic [NUM_REQ-1:0] exp_g [4];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    idle_inputs();
    rst = 1'b1; req = 3'b111;
    tick(); tick();
    @(negedge clk);
    checks++;
    if ({gnt, rvalid, busy, flush_done, pum_rd, pum_wr, pum_addr} !== '0) begin
      errors++;
      $display("FAIL reset_ctl got gnt=%b rvalid=%b busy=%b fd=%b rd=%b wr=%b addr=%h exp all 0",
               gnt, rvalid, busy, flush_done, pum_rd, pum_wr, pum_addr);
    end
    checks++;
    if (rdata !== '0 || pum_wdata !== '0) begin
      errors++;
      $display("FAIL reset_data got rdata=%h wdata=%h exp 0", rdata[63:0], pum_wdata[63:0]);
    end
    tick();
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checks++;
      if (gnt !== exp_g[n]) begin
        errors++;
        $display("FAIL reset_rr_seq%0d got %b exp %b", n, gnt, exp_g[n]);
      end
      tick();
    end
    idle_inputs();
    repeat (6) tick();
  endtask

  task automatic test_read_return();
    do_reset();
    set_req(1, 1'b0, 14'h0010, '0);
    @(negedge clk); checks++;
    if (gnt !== 3'b010) begin errors++; $display("FAIL rd_gnt got %b exp 010", gnt); end
    tick(); req[1] = 1'b0;
    @(negedge clk); checks++;
    if ({pum_rd, pum_wr, pum_addr} !== {2'b10, 14'h0010}) begin
      errors++; $display("FAIL rd_issue got rd=%b wr=%b addr=%h exp 1 0 0010", pum_rd, pum_wr, pum_addr);
    end
    tick();
    @(negedge clk); checks++;
    if (rvalid !== 3'b000 || busy !== 1'b1) begin
      errors++; $display("FAIL rd_wait got rvalid=%b busy=%b exp 000 1", rvalid, busy);
    end
    tick(); pum_rdata = pat(14'h0010);
    @(negedge clk); checks++;
    if (rvalid !== 3'b010 || rdata !== pat(14'h0010)) begin
      errors++; $display("FAIL rd_return got rvalid=%b rdata=%h exp 010 %h", rvalid, rdata[63:0], pat(14'h0010) >> 0);
    end
    tick(); pum_rdata = rnd_dw();
    @(negedge clk); checks++;
    if (rvalid !== 3'b000 || rdata !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL rd_after got rvalid=%b rdata=%h busy=%b exp 000 0 0", rvalid, rdata[63:0], busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_req(0, 1'b0, 14'h0001, '0);
    set_req(2, 1'b0, 14'h0002, '0);
    @(negedge clk); checks++;
    if (gnt !== 3'b001) begin errors++; $display("FAIL b2b_gnt0 got %b exp 001", gnt); end
    tick(); req[0] = 1'b0;
    @(negedge clk); checks++;
    if (gnt !== 3'b100 || pum_rd !== 1'b1 || pum_addr !== 14'h0001) begin
      errors++; $display("FAIL b2b_gnt2 got gnt=%b rd=%b addr=%h exp 100 1 0001", gnt, pum_rd, pum_addr);
    end
    tick(); req[2] = 1'b0;
    @(negedge clk); checks++;
    if (pum_rd !== 1'b1 || pum_addr !== 14'h0002) begin
      errors++; $display("FAIL b2b_issue2 got rd=%b addr=%h exp 1 0002", pum_rd, pum_addr);
    end
    tick(); pum_rdata = pat(14'h0001);
    @(negedge clk); checks++;
    if (rvalid !== 3'b001 || rdata !== pat(14'h0001)) begin
      errors++; $display("FAIL b2b_ret0 got rvalid=%b rdata=%h exp 001", rvalid, rdata[63:0]);
    end
    tick(); pum_rdata = pat(14'h0002);
    @(negedge clk); checks++;
    if (rvalid !== 3'b100 || rdata !== pat(14'h0002) || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_ret2 got rvalid=%b rdata=%h busy=%b exp 100 1", rvalid, rdata[63:0], busy);
    end
    tick(); pum_rdata = rnd_dw();
    @(negedge clk); checks++;
    if (busy !== 1'b0 || rvalid !== 3'b000) begin
      errors++; $display("FAIL b2b_busy_fall got busy=%b rvalid=%b exp 0 000", busy, rvalid);
    end
  endtask

  task automatic test_write();
    logic [DW-1:0] w;
    w = rnd_dw();
    do_reset();
    set_req(2, 1'b1, 14'h3FFF, w);
    @(negedge clk); checks++;
    if (gnt !== 3'b100) begin errors++; $display("FAIL wr_gnt got %b exp 100", gnt); end
    tick(); req[2] = 1'b0;
    @(negedge clk); checks++;
    if ({pum_wr, pum_rd, pum_addr} !== {2'b10, 14'h3FFF} || pum_wdata !== w || busy !== 1'b1) begin
      errors++; $display("FAIL wr_issue got wr=%b rd=%b addr=%h wd=%h busy=%b exp 1 0 3fff %h 1",
                         pum_wr, pum_rd, pum_addr, pum_wdata[63:0], busy, w[63:0]);
    end
    for (int n = 0; n < 3; n++) begin
      tick();
      @(negedge clk); checks++;
      if (rvalid !== 3'b000 || busy !== 1'b0) begin
        errors++; $display("FAIL wr_noret%0d got rvalid=%b busy=%b exp 000 0", n, rvalid, busy);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_req(0, 1'b0, 14'h0101, '0);
    set_req(1, 1'b0, 14'h0202, '0);
    tick(); req[0] = 1'b0;
    tick();
    set_req(0, 1'b0, 14'h0003, '0); set_req(1, 1'b0, 14'h0004, '0); set_req(2, 1'b0, 14'h0005, '0);
    flush = 1'b1;
    @(negedge clk); checks++;
    if (gnt !== 3'b000) begin errors++; $display("FAIL fl_nognt got %b exp 000", gnt); end
    tick(); pum_rdata = pat(14'h0101);
    @(negedge clk); checks++;
    if (gnt !== 3'b000 || rvalid !== 3'b001 || flush_done !== 1'b0) begin
      errors++; $display("FAIL fl_ret0 got gnt=%b rvalid=%b fd=%b exp 000 001 0", gnt, rvalid, flush_done);
    end
    tick(); pum_rdata = pat(14'h0202);
    @(negedge clk); checks++;
    if (rvalid !== 3'b010 || rdata !== pat(14'h0202) || flush_done !== 1'b0) begin
      errors++; $display("FAIL fl_ret1 got rvalid=%b fd=%b exp 010 0", rvalid, flush_done);
    end
    tick(); pum_rdata = rnd_dw();
    @(negedge clk); checks++;
    if (flush_done !== 1'b1 || gnt !== 3'b000 || busy !== 1'b0) begin
      errors++; $display("FAIL fl_done got fd=%b gnt=%b busy=%b exp 1 000 0", flush_done, gnt, busy);
    end
    tick();
    @(negedge clk); checks++;
    if (flush_done !== 1'b0 || gnt !== 3'b000) begin
      errors++; $display("FAIL fl_held got fd=%b gnt=%b exp 0 000", flush_done, gnt);
    end
    tick(); flush = 1'b0;
    @(negedge clk); checks++;
    if (gnt !== 3'b000) begin errors++; $display("FAIL fl_release got %b exp 000", gnt); end
    tick();
    @(negedge clk); checks++;
    if (gnt !== 3'b100 || flush_done !== 1'b0) begin
      errors++; $display("FAIL fl_resume got gnt=%b fd=%b exp 100 0", gnt, flush_done);
    end
    do_reset();
    flush = 1'b1;
    @(negedge clk); checks++;
    if (flush_done !== 1'b0) begin errors++; $display("FAIL fl_idle_early got %b exp 0", flush_done); end
    tick(); flush = 1'b0;
    @(negedge clk); checks++;
    if (flush_done !== 1'b1) begin errors++; $display("FAIL fl_idle_done got %b exp 1", flush_done); end
    tick();
    @(negedge clk); checks++;
    if (flush_done !== 1'b0) begin errors++; $display("FAIL fl_idle_once got %b exp 0", flush_done); end
  endtask

`ifdef XBOX_ARB_BURST_LOCK_EN
  task automatic test_lock();
    do_reset();
    set_req(0, 1'b0, 14'h0011, '0); req_lock[0] = 1'b1;
    set_req(1, 1'b0, 14'h0022, '0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk); checks++;
      if (gnt !== 3'b001) begin errors++; $display("FAIL lock_hold%0d got %b exp 001", n, gnt); end
      tick();
    end
    req[0] = 1'b0; req_lock[0] = 1'b0;
    @(negedge clk); checks++;
    if (gnt !== 3'b010) begin errors++; $display("FAIL lock_release got %b exp 010", gnt); end
    tick(); idle_inputs();
  endtask
`endif

  task automatic test_random();
    int m_ptr, fl_cnt, eg, idx;
    bit m_drn, m_sent, m_done, mc_v, mc_we, due, pend_nxt;
    int mc_id;
    logic [AW-1:0] mc_addr;
    logic [DW-1:0] mc_wd, exp_rd;
    logic [NUM_REQ-1:0] eg_vec, ev;
    ret_t rq[$];
    bit pend[NUM_REQ];
    bit pwe[NUM_REQ];
    logic [AW-1:0] pad[NUM_REQ];
    logic [DW-1:0] pwd[NUM_REQ];
    do_reset();
    m_ptr = 0; fl_cnt = 0; m_drn = 0; m_sent = 0; m_done = 0; mc_v = 0; mc_we = 0;
    mc_id = 0; mc_addr = '0; mc_wd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin pend[i] = 0; pwe[i] = 0; pad[i] = '0; pwd[i] = '0; end
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 350) begin
        rst = 1'b1;
        @(negedge clk); checks++;
        if ({gnt, rvalid, busy, flush_done, pum_rd, pum_wr} !== '0) begin
          errors++; $display("FAIL rnd_midreset c=%0d gnt=%b rvalid=%b busy=%b exp all 0", c, gnt, rvalid, busy);
        end
        m_ptr = 0; fl_cnt = 0; m_drn = 0; m_sent = 0; m_done = 0; mc_v = 0;
        mc_addr = '0; mc_wd = '0; rq.delete();
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 0;
        idle_inputs();
        tick(); rst = 1'b0;
        continue;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 45) begin
          pend[i] = 1; pwe[i] = ($urandom_range(0, 2) == 0);
          pad[i] = AW'($urandom); pwd[i] = rnd_dw();
        end
        req[i] = pend[i]; req_we[i] = pwe[i];
        req_addr[i*AW +: AW] = pad[i]; req_wdata[i*DW +: DW] = pwd[i];
      end
      if (fl_cnt > 0) begin flush = 1'b1; fl_cnt--; end
      else begin flush = 1'b0; if ($urandom_range(0, 99) < 4) fl_cnt = $urandom_range(1, 8); end
      due = (rq.size() > 0) && (rq[0].due == c);
      ev = '0; exp_rd = '0;
      if (due) begin ev[rq[0].id] = 1'b1; exp_rd = pat(rq[0].addr); end
      pum_rdata = due ? exp_rd : rnd_dw();
      @(negedge clk);
      eg = -1;
      if (!flush && !m_drn)
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (m_ptr + k) % NUM_REQ;
          if (eg < 0 && pend[idx]) eg = idx;
        end
      eg_vec = '0;
      if (eg >= 0) eg_vec[eg] = 1'b1;
      checks++;
      if (gnt !== eg_vec) begin errors++; $display("FAIL rnd_gnt c=%0d got %b exp %b", c, gnt, eg_vec); end
      checks++;
      if ({pum_rd, pum_wr} !== {mc_v && !mc_we, mc_v && mc_we} || pum_addr !== mc_addr || pum_wdata !== mc_wd) begin
        errors++; $display("FAIL rnd_cmd c=%0d got rd=%b wr=%b addr=%h exp %b %b %h",
                           c, pum_rd, pum_wr, pum_addr, mc_v && !mc_we, mc_v && mc_we, mc_addr);
      end
      checks++;
      if (rvalid !== ev || rdata !== exp_rd) begin
        errors++; $display("FAIL rnd_ret c=%0d got rvalid=%b rdata=%h exp %b %h", c, rvalid, rdata[63:0], ev, exp_rd[63:0]);
      end
      checks++;
      if (busy !== (mc_v || rq.size() > 0) || flush_done !== m_done) begin
        errors++; $display("FAIL rnd_status c=%0d got busy=%b fd=%b exp %b %b",
                           c, busy, flush_done, mc_v || rq.size() > 0, m_done);
      end
      if (due) void'(rq.pop_front());
      if (mc_v && !mc_we) rq.push_back(ret_t'{c + RD_LAT, mc_id, mc_addr});
      if (eg >= 0) begin
        mc_v = 1; mc_we = pwe[eg]; mc_id = eg; mc_addr = pad[eg]; mc_wd = pwd[eg];
        pend[eg] = 0; m_ptr = (eg + 1) % NUM_REQ;
      end else mc_v = 0;
      pend_nxt = mc_v || (rq.size() > 0);
      m_done = 0;
      if (!m_drn && flush) begin m_drn = 1; m_sent = 0; end
      if (m_drn && !m_sent && !pend_nxt) begin
        m_done = 1; m_sent = 1;
        if (!flush) m_drn = 0;
      end else if (m_drn && m_sent && !flush) m_drn = 0;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_read_return();
    test_back_to_back();
    test_write();
    test_flush();
`ifdef XBOX_ARB_BURST_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
